// File: rtl/uart_rx_if.sv
// Consumer-side bundle of the UART receiver: received byte, valid/ready handshake
// and the one-cycle error pulses.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling from a baud counter,
// one-entry output register with valid/ready handshake, frame-error and overrun pulses.
module uart_rx #(
    parameter int CLK_FREQ  = 10_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    uart_rx_if.master   rx_bus,
    output logic [1:0]  o_dbg_state
);
    // Handshake: rx_valid high means rx_data holds an unconsumed byte and rx_data is
    // stable; the byte is taken at any rising edge where rx_valid & rx_ready are both 1.
    // A byte arriving while the slot is full (and not being drained) is dropped with overrun.

    localparam int          BAUD_DIV  = CLK_FREQ / BAUD_RATE;
    localparam int          HALF_DIV  = BAUD_DIV / 2;
    localparam logic [31:0] BAUD_LAST = 32'(BAUD_DIV - 1);
    localparam logic [31:0] HALF_LAST = 32'(HALF_DIV - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    rx_state_t   r_state;
    rx_state_t   w_next_state;
    logic        r_rx_meta;
    logic        r_rx_s;
    logic        r_rx_s_d;
    logic [31:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_frame_err;
    logic        r_overrun;

    logic        w_cnt_clr;
    logic        w_cnt_inc;
    logic        w_bit_clr;
    logic        w_sample_data;
    logic        w_stop_tick;
    logic        w_stop_good;
    logic        w_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_s_d  <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_s_d  <= r_rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RX_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state  = r_state;
        w_cnt_clr     = 1'b0;
        w_cnt_inc     = 1'b0;
        w_bit_clr     = 1'b0;
        w_sample_data = 1'b0;
        w_stop_tick   = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cnt_clr = 1'b1;
                // Edge-triggered so a line stuck low after a bad frame cannot restart.
                if (r_rx_s_d && !r_rx_s) w_next_state = RX_START;
            end
            RX_START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_clr    = 1'b1;
                    w_bit_clr    = !r_rx_s;
                    w_next_state = r_rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            RX_DATA: begin
                if (r_cnt == BAUD_LAST) begin
                    w_cnt_clr     = 1'b1;
                    w_sample_data = 1'b1;
                    if (r_bit_idx == 3'd7) w_next_state = RX_STOP;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            RX_STOP: begin
                if (r_cnt == BAUD_LAST) begin
                    w_cnt_clr    = 1'b1;
                    w_stop_tick  = 1'b1;
                    w_next_state = RX_IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: w_next_state = RX_IDLE;
        endcase
    end

    assign w_stop_good = w_stop_tick && r_rx_s;
    assign w_load      = w_stop_good && (!r_rx_valid || rx_bus.rx_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + 32'd1;
            if (w_bit_clr) begin
                r_bit_idx <= '0;
            end else if (w_sample_data) begin
                r_shift[r_bit_idx] <= r_rx_s;
                r_bit_idx          <= r_bit_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_tick && !r_rx_s;
            r_overrun   <= w_stop_good && r_rx_valid && !rx_bus.rx_ready;
            if (w_load) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_bus.rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_bus.rx_data   = r_rx_data;
    assign rx_bus.rx_valid  = r_rx_valid;
    assign rx_bus.frame_err = r_frame_err;
    assign rx_bus.overrun   = r_overrun;
    assign o_dbg_state      = r_state;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 10_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate in bits/s.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rx  input  1  UART serial input pin, asynchronous to clk, idle high.
REQ-006 SHALL have port rx_data  output  8  received byte, held stable while rx_valid=1.
REQ-007 SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-008 SHALL have port rx_ready  input  1  consumer accepts rx_data when rx_valid&rx_ready at a rising edge.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse: good byte arrived while previous byte still unconsumed.

Function
REQ-011 SHALL use frame format 1 start bit (low), 8 data bits LSB first, 1 stop bit (high), no parity.
REQ-012 SHALL define BAUD_DIV = CLK_FREQ/BAUD_RATE (integer division) and HALF_DIV = BAUD_DIV/2; the baud counter SHALL be 32 bits wide.
REQ-013 SHALL pass rx through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rx_s, plus a registered copy rx_s_d for edge detection.
REQ-014 SHALL implement states RX_IDLE, RX_START, RX_DATA, RX_STOP.
REQ-015 RX_IDLE: baud counter held at 0; on falling edge (rx_s_d=1, rx_s=0) -> RX_START. A line held low does not retrigger.
REQ-016 RX_START: counter counts up; at count HALF_DIV-1: rx_s=0 -> RX_DATA with counter cleared to 0 and bit index 0; rx_s=1 -> RX_IDLE (glitch rejected, no outputs change).
REQ-017 RX_DATA: at count BAUD_DIV-1 (bit centre) sample rx_s into bit position bit_index of the shift register, clear counter, increment bit_index; after the 8th sample -> RX_STOP.
REQ-018 RX_STOP: at count BAUD_DIV-1 sample rx_s, then -> RX_IDLE.
REQ-019 Stop sample=1 and rx_valid=0, or rx_valid=1 with rx_ready=1 in that same cycle: rx_data <= shift register, rx_valid <= 1 at the next edge (no overrun).
REQ-020 Stop sample=1, rx_valid=1, rx_ready=0: new byte discarded, rx_data/rx_valid unchanged, overrun pulses 1 cycle.
REQ-021 Stop sample=0: byte discarded, frame_err pulses 1 cycle, rx_valid/rx_data unchanged; a new start requires a high-then-low edge.
REQ-022 rx_valid & rx_ready without a concurrent byte load SHALL clear rx_valid at that edge; rx_data keeps its last value.
REQ-023 Latency: rx_valid rises on the clock edge following the stop-bit sample edge, i.e. at most 2 sync + HALF_DIV + 9*BAUD_DIV + 1 cycles after the rx falling edge.
REQ-024 Reception SHALL proceed independently of rx_ready; receiver never stalls the line.

Reset
REQ-025 On rst=1, immediately: state RX_IDLE, counter 0, bit_index 0, shift register 0, synchronizer flops 1, rx_data 0x00, rx_valid 0, frame_err 0, overrun 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame; after release, no byte from the partial frame is delivered, and the next falling edge starts a fresh frame.

Verification (CLK_FREQ=10 MHz, BAUD_RATE=115200: BAUD_DIV=86, HALF_DIV=43)
REQ-027 Send 0xA5 with rx_ready=1 -> single rx_valid pulse with rx_data=0xA5, frame_err=0, overrun=0.
REQ-028 Send 0x3C with rx_ready=0, then 0x7E -> rx_data stays 0x3C, rx_valid stays 1, overrun pulses once at the second stop sample; after rx_ready, rx_valid falls.
REQ-029 Send 0x55 with stop bit driven low -> frame_err pulses once, rx_valid stays 0; hold rx low 20 bit times then send 0x12 -> only 0x12 delivered.
REQ-030 Drive rx low for 20 cycles (< HALF_DIV) then high -> no frame_err, no rx_valid, FSM back in RX_IDLE.
REQ-031 Assert rst during data bit 4 of 0xFF, release, then send 0x81 -> only 0x81 delivered, outputs at reset values in between.
REQ-032 Back-to-back frames 0x00, 0xFF, 0x01 with rx_ready=1 and rx_ready/load coinciding on the second -> all three delivered in order, no overrun.
